// File: rtl/encrypt_ingress_fifo.sv
// Ingress byte FIFO ahead of the encrypt/decrypt wrapper: valid/ready in, enable+data pulses out.
// Optional issued-byte counter (tx_count port) is built when TX_COUNT_EN is defined.
module encrypt_ingress_fifo #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned DATA_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DATA_W-1:0]      in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   hold,
    output logic [DATA_W-1:0]      out_data,
    output logic                   out_enable,
    output logic [$clog2(DEPTH):0] level,
    output logic                   full,
    output logic                   empty
`ifdef TX_COUNT_EN
    ,
    output logic [15:0]            tx_count
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              push;
    logic              pop;

    // Pointer MSB is the wrap bit: equal addresses with differing wrap bits means full.
    assign full     = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign empty    = (wr_ptr == rd_ptr);
    assign level    = wr_ptr - rd_ptr;
    assign in_ready = rst & ~full;
    assign push     = in_valid & in_ready;
    assign pop      = ~empty & ~hold;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            out_data   <= '0;
            out_enable <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                out_data   <= mem[rd_ptr[AW-1:0]];
                out_enable <= 1'b1;
                rd_ptr     <= rd_ptr + PW'(1);
            end else begin
                out_enable <= 1'b0;
            end
        end
    end

`ifdef TX_COUNT_EN
    // Counts every issued byte; wraps naturally at 16 bits.
    always_ff @(posedge clk) begin
        if (!rst) begin
            tx_count <= '0;
        end else if (pop) begin
            tx_count <= tx_count + 16'd1;
        end
    end
`endif

endmodule
